fft_dif_seq_ctrl: RTL and testbench

Sequencer for the shared-resource radix-2 DIF butterfly in an in-place N-point FFT. It walks all log2(N) stages, issues one butterfly every 2 cycles, and generates the data-memory read and write addresses and the twiddle-ROM address. It also provides the butterfly phase-alignment clear and drains the pipeline between stages to avoid in-place read-after-write hazards. It sits between the top-level FFT start/done handshake and the data RAM, twiddle ROM and butterfly.

---
 rtl/fft_dif_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fft_dif_seq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fft_dif_seq_ctrl.sv
// fft_dif_seq_ctrl: stage/butterfly sequencer for an in-place radix-2 DIF FFT
// built around one shared butterfly. Issues a butterfly read every 2 cycles,
// drains the butterfly pipeline between stages, and replays the read
// addresses PIPE_DELAY cycles later as the write addresses.
// Optional build macro: BITREV_WR_EN - final-stage write addresses are
// bit-reversed so the data memory ends up holding natural-order output.
module fft_dif_seq_ctrl #(
    parameter int N_LOG2     = 4,
    parameter int PIPE_DELAY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                bfly_clr,
    output logic                rd_en,
    output logic [N_LOG2-1:0]   rd_addr0,
    output logic [N_LOG2-1:0]   rd_addr1,
    output logic [N_LOG2-2:0]   tw_addr,
    output logic                wr_en,
    output logic [N_LOG2-1:0]   wr_addr0,
    output logic [N_LOG2-1:0]   wr_addr1,
    output logic [N_LOG2-1:0]   stage
);
    localparam int TW_WIDTH = N_LOG2 - 1;
    localparam int JW       = N_LOG2 - 1;
    localparam int CW       = $clog2(PIPE_DELAY + 1);
    localparam logic [JW-1:0]     J_LAST = '1;
    localparam logic [N_LOG2-1:0] S_LAST = N_LOG2'(N_LOG2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state_reg;
    logic [N_LOG2-1:0]     stage_reg;
    logic [JW-1:0]         j_reg;
    logic                  phase_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  busy_reg, done_reg, bfly_clr_reg, rd_en_reg;
    logic [N_LOG2-1:0]     rd_addr0_reg, rd_addr1_reg;
    logic [TW_WIDTH-1:0]   tw_addr_reg;
    logic                  wr_en_reg;
    logic [N_LOG2-1:0]     wr_addr0_reg, wr_addr1_reg;

    // Write-address delay line; the output registers form its last tap
    logic [PIPE_DELAY-2:0] pv_reg;
    logic [N_LOG2-1:0]     pa0_reg [PIPE_DELAY-1];
    logic [N_LOG2-1:0]     pa1_reg [PIPE_DELAY-1];

    logic [N_LOG2-1:0]     jw_next, h_next, hmask_next, a0_next, a1_next;
    logic [TW_WIDTH-1:0]   tw_next;
    logic [N_LOG2-1:0]     win0_next, win1_next;

    // Butterfly addressing: insert a 0 at bit N_LOG2-1-s of j, partner is +h
    always_comb begin
        jw_next    = {1'b0, j_reg};
        h_next     = N_LOG2'(1) << (S_LAST - stage_reg);
        hmask_next = h_next - N_LOG2'(1);
        a0_next    = ((jw_next & ~hmask_next) << 1) | (jw_next & hmask_next);
        a1_next    = a0_next | h_next;
        tw_next    = TW_WIDTH'((jw_next & hmask_next) << stage_reg);
    end

`ifdef BITREV_WR_EN
    logic [N_LOG2-1:0] rev0, rev1;
    genvar gi;
    generate
        for (gi = 0; gi < N_LOG2; gi++) begin : g_rev
            assign rev0[gi] = rd_addr0_reg[N_LOG2-1-gi];
            assign rev1[gi] = rd_addr1_reg[N_LOG2-1-gi];
        end
    endgenerate

    // Final-stage writes land in bit-reversed slots (stage is stable here)
    always_comb begin
        win0_next = rd_addr0_reg;
        win1_next = rd_addr1_reg;
        if (stage_reg == S_LAST) begin
            win0_next = rev0;
            win1_next = rev1;
        end
    end
`else
    // Writes go back in place to the addresses that were read
    always_comb begin
        win0_next = rd_addr0_reg;
        win1_next = rd_addr1_reg;
    end
`endif

    // Sequencer FSM: issue slots, inter-stage drain and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            stage_reg    <= '0;
            j_reg        <= '0;
            phase_reg    <= 1'b0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bfly_clr_reg <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_addr0_reg <= '0;
            rd_addr1_reg <= '0;
            tw_addr_reg  <= '0;
        end else begin
            bfly_clr_reg <= 1'b0;
            rd_en_reg    <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // done_reg blocks a start arriving in the done cycle
                    if (start && !done_reg) begin
                        state_reg    <= RUN;
                        stage_reg    <= '0;
                        j_reg        <= '0;
                        phase_reg    <= 1'b0;
                        bfly_clr_reg <= 1'b1;
                    end
                end
                RUN: begin
                    busy_reg <= 1'b1;
                    if (!phase_reg) begin
                        rd_en_reg    <= 1'b1;
                        rd_addr0_reg <= a0_next;
                        rd_addr1_reg <= a1_next;
                        tw_addr_reg  <= tw_next;
                        phase_reg    <= 1'b1;
                        if (j_reg == J_LAST) begin
                            state_reg <= DRAIN;
                            cnt_reg   <= CW'(PIPE_DELAY - 1);
                        end
                    end else begin
                        phase_reg <= 1'b0;
                        j_reg     <= j_reg + JW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt_reg == '0) begin
                        if (stage_reg == S_LAST) begin
                            state_reg <= FIN;
                        end else begin
                            stage_reg <= stage_reg + N_LOG2'(1);
                            j_reg     <= '0;
                            phase_reg <= 1'b0;
                            state_reg <= RUN;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Delay line carrying {valid, addr0, addr1} from the read to the write side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_reg <= '0;
            for (int i = 0; i < PIPE_DELAY - 1; i++) begin
                pa0_reg[i] <= '0;
                pa1_reg[i] <= '0;
            end
        end else begin
            pv_reg[0]  <= rd_en_reg;
            pa0_reg[0] <= win0_next;
            pa1_reg[0] <= win1_next;
            for (int i = 1; i < PIPE_DELAY - 1; i++) begin
                pv_reg[i]  <= pv_reg[i-1];
                pa0_reg[i] <= pa0_reg[i-1];
                pa1_reg[i] <= pa1_reg[i-1];
            end
        end
    end

    // Final tap: write strobe lands exactly PIPE_DELAY cycles after rd_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg    <= 1'b0;
            wr_addr0_reg <= '0;
            wr_addr1_reg <= '0;
        end else begin
            wr_en_reg    <= pv_reg[PIPE_DELAY-2];
            wr_addr0_reg <= pa0_reg[PIPE_DELAY-2];
            wr_addr1_reg <= pa1_reg[PIPE_DELAY-2];
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign bfly_clr = bfly_clr_reg;
    assign rd_en    = rd_en_reg;
    assign rd_addr0 = rd_addr0_reg;
    assign rd_addr1 = rd_addr1_reg;
    assign tw_addr  = tw_addr_reg;
    assign wr_en    = wr_en_reg;
    assign wr_addr0 = wr_addr0_reg;
    assign wr_addr1 = wr_addr1_reg;
    assign stage    = stage_reg;
endmodule

// File: tb/tb_fft_dif_seq_ctrl.sv
// Directed bench for fft_dif_seq_ctrl: an N=8/PIPE_DELAY=4 instance is checked
// cycle by cycle against hand-written read/write tables, and an
// N=16/PIPE_DELAY=2 instance is checked for stage timing and done latency.
module tb_fft_dif_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start6 = 1'b0;

    logic       busy, done, bfly_clr, rd_en, wr_en;
    logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1, stage;
    logic [1:0] tw_addr;

    logic       busy6, done6, bfly_clr6, rd_en6, wr_en6;
    logic [3:0] rd_addr0_6, rd_addr1_6, wr_addr0_6, wr_addr1_6, stage6;
    logic [2:0] tw_addr6;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Hand-derived N=8 schedule: read cycles, read pairs, twiddles
    int rd_cyc [12] = '{1, 3, 5, 7, 12, 14, 16, 18, 23, 25, 27, 29};
    int rd_a0  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int rd_a1  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int rd_tw  [12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
`ifdef BITREV_WR_EN
    int wr_a0  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 1, 3};
    int wr_a1  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 4, 6, 5, 7};
`else
    int wr_a0  [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int wr_a1  [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
`endif

    fft_dif_seq_ctrl #(.N_LOG2(3), .PIPE_DELAY(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .bfly_clr(bfly_clr), .rd_en(rd_en), .rd_addr0(rd_addr0),
        .rd_addr1(rd_addr1), .tw_addr(tw_addr), .wr_en(wr_en),
        .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .stage(stage)
    );

    fft_dif_seq_ctrl #(.N_LOG2(4), .PIPE_DELAY(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .busy(busy6), .done(done6),
        .bfly_clr(bfly_clr6), .rd_en(rd_en6), .rd_addr0(rd_addr0_6),
        .rd_addr1(rd_addr1_6), .tw_addr(tw_addr6), .wr_en(wr_en6),
        .wr_addr0(wr_addr0_6), .wr_addr1(wr_addr1_6), .stage(stage6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every N=8 output in cycle c of a run (c=0 is the start edge)
    task automatic check_run(input int c);
        int kr, kw;
        kr = -1;
        kw = -1;
        cyc = c;
        for (int k = 0; k < 12; k++) begin
            if (rd_cyc[k] == c) kr = k;
            if (rd_cyc[k] + 4 == c) kw = k;
        end
        chk("bfly_clr", 32'(bfly_clr), 32'(c == 0));
        chk("busy", 32'(busy), 32'(c >= 1 && c <= 33));
        chk("done", 32'(done), 32'(c == 34));
        chk("rd_en", 32'(rd_en), 32'(kr >= 0));
        chk("wr_en", 32'(wr_en), 32'(kw >= 0));
        if (kr >= 0) begin
            chk("rd_addr0", 32'(rd_addr0), rd_a0[kr]);
            chk("rd_addr1", 32'(rd_addr1), rd_a1[kr]);
            chk("tw_addr", 32'(tw_addr), rd_tw[kr]);
            chk("stage", 32'(stage), kr / 4);
        end
        if (kw >= 0) begin
            chk("wr_addr0", 32'(wr_addr0), wr_a0[kw]);
            chk("wr_addr1", 32'(wr_addr1), wr_a1[kw]);
        end
        $display("cycle %0d: rd_en=%0b rd=(%0d,%0d) tw=%0d wr_en=%0b wr=(%0d,%0d) busy=%0b done=%0b",
                 c, rd_en, rd_addr0, rd_addr1, tw_addr, wr_en, wr_addr0, wr_addr1, busy, done);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_bfly_clr"}, 32'(bfly_clr), 0);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_rd_addr"}, 32'({rd_addr0, rd_addr1, tw_addr}), 0);
        chk({tag, "_wr_addr"}, 32'({wr_addr0, wr_addr1, stage}), 0);
    endtask

    initial begin
        int rcount, wcount, s6, o6;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Runs 1 and 2: start during busy/done ignored, second start at edge 40
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            check_run(c % 40);
            start = ((c % 40) == 8) || ((c % 40) == 34) || (c == 39);
            tick();
        end
        start = 1'b0;

        // Reset in cycle 15 aborts the transform with no done pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            check_run(c);
            if (c < 15) tick();
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end

        // Fresh start after reset restarts stage 0 at j=0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check_run(c);
            tick();
        end

        // N=16, PIPE_DELAY=2: 17-cycle stages, done in cycle 69
        rcount = 0;
        wcount = 0;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int c = 0; c < 76; c++) begin
            cyc = c;
            s6 = (c - 1) / 17;
            o6 = (c - 1) % 17;
            if (rd_en6) rcount++;
            if (wr_en6) wcount++;
            chk("n16_bfly_clr", 32'(bfly_clr6), 32'(c == 0));
            chk("n16_done", 32'(done6), 32'(c == 69));
            chk("n16_busy", 32'(busy6), 32'(c >= 1 && c <= 68));
            chk("n16_rd_en", 32'(rd_en6), 32'(c >= 1 && c <= 66 && (o6 % 2) == 0 && o6 <= 14));
            if (c == 3) begin
                chk("n16_rd3", 32'({rd_addr0_6, rd_addr1_6, tw_addr6}), 32'({4'd1, 4'd9, 3'd1}));
                chk("n16_wr3", 32'({wr_addr0_6, wr_addr1_6}), 32'({4'd0, 4'd8}));
            end
            if (c == 20)
                chk("n16_rd20", 32'({rd_addr0_6, rd_addr1_6, tw_addr6, stage6}),
                    32'({4'd1, 4'd5, 3'd2, 4'd1}));
            if (c == 52)
                chk("n16_rd52", 32'({rd_addr0_6, rd_addr1_6, tw_addr6, stage6}),
                    32'({4'd0, 4'd1, 3'd0, 4'd3}));
            if (c == 68) begin
`ifdef BITREV_WR_EN
                chk("n16_wr68", 32'({wr_en6, wr_addr0_6, wr_addr1_6}), 32'({1'b1, 4'd7, 4'd15}));
`else
                chk("n16_wr68", 32'({wr_en6, wr_addr0_6, wr_addr1_6}), 32'({1'b1, 4'd14, 4'd15}));
`endif
            end
            if (s6 < 0) s6 = 0;
            $display("n16 cycle %0d: stage=%0d rd_en=%0b rd=(%0d,%0d) wr_en=%0b wr=(%0d,%0d) done=%0b",
                     c, stage6, rd_en6, rd_addr0_6, rd_addr1_6, wr_en6, wr_addr0_6, wr_addr1_6, done6);
            tick();
        end
        chk("n16_rd_count", rcount, 32);
        chk("n16_wr_count", wcount, 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
